mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single byte-wide memory port between the multicycle CPU controller
//  (IF1/IF2, MEM_READ and MEM_STORE accesses) and a DMA/debug loader port.
//  Each access is sequenced through a request/grant FSM; cpu_stall holds the CPU
//  controller in its current state until its access completes.
//  Sits between the control/datapath memory strobes and the memory macro.
// PARAMETERS
//  ADDR_WIDTH  16  memory address width
//  DATA_WIDTH  8   memory data width (one byte; 16-bit instructions take two accesses)
//  MEM_LAT     1   cycles mem_rd/mem_wr are held per access (>=1)
//  LOCK_MAX    8   max consecutive locked DMA grants before forced release (>=1)
// PORTS
//  clk         in   1   clock, all state changes on rising edge
//  reset       in   1   asynchronous, active-low reset
//  cpu_req     in   1   CPU access request, held until cpu_gnt
//  cpu_we      in   1   1=write, 0=read (sampled with cpu_req)
//  cpu_addr    in   AW  CPU address
//  cpu_wdata   in   DW  CPU write data
//  cpu_gnt     out  1   1-cycle pulse: CPU access complete
//  cpu_rvalid  out  1   1-cycle pulse with cpu_gnt on reads
//  cpu_rdata   out  DW  read data, valid when cpu_rvalid; holds otherwise
//  cpu_stall   out  1   cpu_req & ~cpu_gnt (combinational)
//  dma_req/dma_we/dma_addr/dma_wdata   in   same as CPU side
//  dma_lock    in   1   keep the port for back-to-back DMA accesses
//  dma_gnt/dma_rvalid/dma_rdata        out  same as CPU side
//  mem_addr    out  AW  registered address to memory
//  mem_wdata   out  DW  registered write data
//  mem_rd      out  1   read strobe
//  mem_wr      out  1   write strobe
//  mem_rdata   in   DW  memory read data, sampled in last access cycle
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; all strobes, gnt, rvalid = 0; mem_addr,
//    mem_wdata, *_rdata = 0; last_owner = DMA; lock_cnt = 0. Reset mid-access aborts it.
//  - States: IDLE -> ACC (MEM_LAT cycles, strobe high) -> RESP (1 cycle) -> IDLE/ACC.
//  - Arbitration in IDLE and RESP: winner's addr/wdata/we latched, ACC entered next cycle.
//  - Latency: req seen in IDLE at cycle 0 -> strobes high cycles 1..MEM_LAT ->
//    gnt (and rvalid on reads) in cycle MEM_LAT+1. Back-to-back: RESP arbitrates,
//    so next access strobes start the cycle after RESP.
//  - mem_rd and mem_wr are never both 1; both 0 outside ACC.
//  - Requester dropping req before gnt: latched access still completes, gnt still pulses.
//  - Default priority: CPU wins simultaneous requests.
//  - Lock: in RESP of a DMA access with dma_lock & dma_req & lock_cnt<LOCK_MAX-1,
//    DMA wins regardless of cpu_req; lock_cnt increments. At LOCK_MAX, or on any
//    CPU grant, lock_cnt clears and that arbitration ignores dma_lock.
//  - Owner counter/lock_cnt saturate; no wrap.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: simultaneous requests go to the requester not in
//    last_owner (round robin); dma_lock still overrides within LOCK_MAX.
//  Not defined: strict CPU priority; last_owner register is not built.
// STRUCTURE
//  params.v: MARB_IDLE/MARB_ACC/MARB_RESP state encodings, MARB_OWNER_CPU/DMA,
//  shared with control for stall handling.
//  Sub-module mem_arb_pick: combinational winner select from reqs, last_owner, lock.
// TESTING
//  1 MEM_LAT=1, cpu_req read addr 0x0010, mem_rdata=0xA5 -> strobe cycle 1,
//    cpu_gnt+cpu_rvalid cycle 2, cpu_rdata=0xA5, cpu_stall high cycles 0-1.
//  2 cpu_req and dma_req same cycle, no macro -> CPU served first, DMA gnt 2 cycles later;
//    with MEM_ARB_RR_EN, last_owner=DMA after reset -> CPU first, then alternate.
//  3 dma_lock=1, dma_req continuous, cpu_req held, LOCK_MAX=4 -> 4 DMA grants
//    then CPU grant, lock_cnt=0.
//  4 DMA write 0x3C to 0x0100, MEM_LAT=3 -> mem_wr high exactly 3 cycles,
//    mem_rd low, dma_gnt 1 pulse, dma_rvalid stays 0.
//  5 reset low during ACC -> mem_rd/mem_wr drop same cycle, no gnt, IDLE after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encodings, owner
// encodings (also used by the CPU control unit for stall handling), the
// arbitration result record and a counter-width helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      MARB_IDLE = 2'd0,
      MARB_ACC  = 2'd1,
      MARB_RESP = 2'd2
   } marb_state_e;

   typedef enum logic {
      MARB_OWNER_CPU = 1'b0,
      MARB_OWNER_DMA = 1'b1
   } marb_owner_e;

   typedef struct packed {
      logic        valid;
      marb_owner_e winner;
      logic        lockTake;
      logic        lockClear;
   } marb_pick_t;

   // Bits needed to hold values 0..maxVal, never less than one bit.
   function automatic int marbCntWidth(input int maxVal);
      return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select for the memory port arbiter.
// In the response cycle the request of the access being answered is still
// asserted (requesters hold req until gnt), so it is masked out; only an
// active dma_lock turns the held DMA request into a back-to-back access.
// With MEM_ARB_RR_EN defined, simultaneous requests alternate using the
// last owner; otherwise the CPU always wins a tie.
module mem_port_arbiter_pick
   import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  marb_owner_e last_owner_i,
`endif
   input  logic        cpu_req_i,
   input  logic        dma_req_i,
   input  logic        dma_lock_i,
   input  logic        in_resp_i,
   input  marb_owner_e owner_i,
   input  logic        lock_ok_i,
   output marb_pick_t  pick_o
);

   logic cpuReq;
   logic dmaReq;
   logic lockElig;
   logic lockTake;

   assign cpuReq   = cpu_req_i & ~(in_resp_i & (owner_i == MARB_OWNER_CPU));
   assign dmaReq   = dma_req_i & ~(in_resp_i & (owner_i == MARB_OWNER_DMA));
   assign lockElig = in_resp_i & (owner_i == MARB_OWNER_DMA) & dma_lock_i & dma_req_i;
   assign lockTake = lockElig & lock_ok_i;

   // Pick the winner and decide what happens to the lock counter
   always_comb begin
      pick_o          = '0;
      pick_o.lockTake = lockTake;
      if (lockTake) begin
         pick_o.valid  = 1'b1;
         pick_o.winner = MARB_OWNER_DMA;
      end else if (cpuReq && dmaReq) begin
         pick_o.valid  = 1'b1;
`ifdef MEM_ARB_RR_EN
         pick_o.winner = (last_owner_i == MARB_OWNER_CPU) ? MARB_OWNER_DMA : MARB_OWNER_CPU;
`else
         pick_o.winner = MARB_OWNER_CPU;
`endif
      end else if (cpuReq) begin
         pick_o.valid  = 1'b1;
         pick_o.winner = MARB_OWNER_CPU;
      end else if (dmaReq) begin
         pick_o.valid  = 1'b1;
         pick_o.winner = MARB_OWNER_DMA;
      end
      pick_o.lockClear = ~lockTake &
                         (lockElig | (pick_o.valid & (pick_o.winner == MARB_OWNER_CPU)));
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single byte-wide memory port between the multicycle CPU
// controller and a DMA/debug loader. Each access runs IDLE -> ACC (MEM_LAT
// strobe cycles) -> RESP (grant pulse); arbitration happens in IDLE and RESP
// so back-to-back accesses lose no cycle. dma_lock keeps the port for up to
// LOCK_MAX consecutive DMA accesses.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break, builds the
// last-owner register). Without it the CPU wins every tie.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_LAT    = 1,
   parameter int LOCK_MAX   = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic                  cpu_gnt_o,
   output logic                  cpu_rvalid_o,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,
   output logic                  cpu_stall_o,
   input  logic                  dma_req_i,
   input  logic                  dma_we_i,
   input  logic [ADDR_WIDTH-1:0] dma_addr_i,
   input  logic [DATA_WIDTH-1:0] dma_wdata_i,
   input  logic                  dma_lock_i,
   output logic                  dma_gnt_o,
   output logic                  dma_rvalid_o,
   output logic [DATA_WIDTH-1:0] dma_rdata_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int LATW = marbCntWidth(MEM_LAT);
   localparam int LCW  = marbCntWidth(LOCK_MAX);
   localparam logic [LATW-1:0] ACC_LAST   = LATW'(MEM_LAT - 1);
   localparam logic [LCW-1:0]  LOCK_LIMIT = LCW'(LOCK_MAX - 1);
   localparam logic [LCW-1:0]  LOCK_SAT   = {LCW{1'b1}};

   marb_state_e           state_q,    state_d;
   logic [LATW-1:0]       accCnt_q,   accCnt_d;
   marb_owner_e           owner_q,    owner_d;
   logic                  we_q,       we_d;
   logic [ADDR_WIDTH-1:0] memAddr_q,  memAddr_d;
   logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
   logic [DATA_WIDTH-1:0] cpuRdata_q, cpuRdata_d;
   logic [DATA_WIDTH-1:0] dmaRdata_q, dmaRdata_d;
   logic [LCW-1:0]        lockCnt_q,  lockCnt_d;
`ifdef MEM_ARB_RR_EN
   marb_owner_e           lastOwner_q, lastOwner_d;
`endif

   marb_pick_t pick;
   logic       arbActive;
   logic       grantNow;
   logic       lastAccCycle;

   assign arbActive    = (state_q == MARB_IDLE) || (state_q == MARB_RESP);
   assign grantNow     = arbActive & pick.valid;
   assign lastAccCycle = (state_q == MARB_ACC) && (accCnt_q == ACC_LAST);

   mem_port_arbiter_pick uPick (
`ifdef MEM_ARB_RR_EN
      .last_owner_i (lastOwner_q),
`endif
      .cpu_req_i    (cpu_req_i),
      .dma_req_i    (dma_req_i),
      .dma_lock_i   (dma_lock_i),
      .in_resp_i    (state_q == MARB_RESP),
      .owner_i      (owner_q),
      .lock_ok_i    (lockCnt_q < LOCK_LIMIT),
      .pick_o       (pick)
   );

   // State register and access-cycle counter; reset aborts any access
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= MARB_IDLE;
         accCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         accCnt_q <= accCnt_d;
      end
   end

   // Next state: hold ACC for MEM_LAT cycles, re-arbitrate from IDLE/RESP
   always_comb begin
      state_d  = state_q;
      accCnt_d = '0;
      case (state_q)
         MARB_IDLE: begin
            if (grantNow) state_d = MARB_ACC;
         end
         MARB_ACC: begin
            if (accCnt_q == ACC_LAST) begin
               state_d = MARB_RESP;
            end else begin
               accCnt_d = accCnt_q + LATW'(1);
            end
         end
         MARB_RESP: begin
            state_d = grantNow ? MARB_ACC : MARB_IDLE;
         end
         default: state_d = MARB_IDLE;
      endcase
   end

   // Strobes and grant pulses are decoded from the registered state
   always_comb begin
      mem_rd_o     = 1'b0;
      mem_wr_o     = 1'b0;
      cpu_gnt_o    = 1'b0;
      cpu_rvalid_o = 1'b0;
      dma_gnt_o    = 1'b0;
      dma_rvalid_o = 1'b0;
      if (state_q == MARB_ACC) begin
         mem_rd_o = ~we_q;
         mem_wr_o = we_q;
      end
      if (state_q == MARB_RESP) begin
         if (owner_q == MARB_OWNER_CPU) begin
            cpu_gnt_o    = 1'b1;
            cpu_rvalid_o = ~we_q;
         end else begin
            dma_gnt_o    = 1'b1;
            dma_rvalid_o = ~we_q;
         end
      end
      cpu_stall_o = cpu_req_i & ~cpu_gnt_o;
   end

   assign mem_addr_o  = memAddr_q;
   assign mem_wdata_o = memWdata_q;
   assign cpu_rdata_o = cpuRdata_q;
   assign dma_rdata_o = dmaRdata_q;

   // Latch the winner's command when a grant is decided
   always_comb begin
      owner_d    = owner_q;
      we_d       = we_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      if (grantNow) begin
         owner_d = pick.winner;
         if (pick.winner == MARB_OWNER_CPU) begin
            we_d       = cpu_we_i;
            memAddr_d  = cpu_addr_i;
            memWdata_d = cpu_wdata_i;
         end else begin
            we_d       = dma_we_i;
            memAddr_d  = dma_addr_i;
            memWdata_d = dma_wdata_i;
         end
      end
   end

   // Capture read data in the last strobe cycle for the owning requester
   always_comb begin
      cpuRdata_d = cpuRdata_q;
      dmaRdata_d = dmaRdata_q;
      if (lastAccCycle && !we_q) begin
         if (owner_q == MARB_OWNER_CPU) cpuRdata_d = mem_rdata_i;
         else                           dmaRdata_d = mem_rdata_i;
      end
   end

   // Count locked DMA grants; a CPU grant or the limit clears the count
   always_comb begin
      lockCnt_d = lockCnt_q;
      if (arbActive) begin
         if (pick.lockTake) begin
            if (lockCnt_q != LOCK_SAT) lockCnt_d = lockCnt_q + LCW'(1);
         end else if (pick.lockClear) begin
            lockCnt_d = '0;
         end
      end
   end

   // Command, read-data and lock registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         owner_q    <= MARB_OWNER_DMA;
         we_q       <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         cpuRdata_q <= '0;
         dmaRdata_q <= '0;
         lockCnt_q  <= '0;
      end else begin
         owner_q    <= owner_d;
         we_q       <= we_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
         cpuRdata_q <= cpuRdata_d;
         dmaRdata_q <= dmaRdata_d;
         lockCnt_q  <= lockCnt_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember who won last so ties alternate
   always_comb begin
      lastOwner_d = grantNow ? pick.winner : lastOwner_q;
   end

   // Last-owner register starts at DMA so the CPU wins the first tie
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lastOwner_q <= MARB_OWNER_DMA;
      else         lastOwner_q <= lastOwner_d;
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-timestamp model of the arbiter.
module tb_mem_port_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 8;
   localparam int ML  = 3;
   localparam int LM  = 4;
   localparam int CPU = 0;
   localparam int DMA = 1;

   logic          clk;
   logic          rst_n;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata, dma_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_rd, mem_wr;

   int errors = 0;
   int checks = 0;

   // model state: the access in flight is described by its start cycle
   int            cyc, mStart, mOwner, mLockCnt, mLastOwner;
   bit            mActive, mWe, cpuGntLast, dmaGntLast;
   logic [AW-1:0] mMemAddr;
   logic [DW-1:0] mMemWdata, mCap, mCpuRdata, mDmaRdata;

   mem_port_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_LAT    (ML),
      .LOCK_MAX   (LM)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cpu_req_i    (cpu_req),
      .cpu_we_i     (cpu_we),
      .cpu_addr_i   (cpu_addr),
      .cpu_wdata_i  (cpu_wdata),
      .cpu_gnt_o    (cpu_gnt),
      .cpu_rvalid_o (cpu_rvalid),
      .cpu_rdata_o  (cpu_rdata),
      .cpu_stall_o  (cpu_stall),
      .dma_req_i    (dma_req),
      .dma_we_i     (dma_we),
      .dma_addr_i   (dma_addr),
      .dma_wdata_i  (dma_wdata),
      .dma_lock_i   (dma_lock),
      .dma_gnt_o    (dma_gnt),
      .dma_rvalid_o (dma_rvalid),
      .dma_rdata_o  (dma_rdata),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rd_o     (mem_rd),
      .mem_wr_o     (mem_wr),
      .mem_rdata_i  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
      end
   endtask

   task automatic modelReset();
      cyc        = 0;
      mStart     = 0;
      mOwner     = DMA;
      mLockCnt   = 0;
      mLastOwner = DMA;
      mActive    = 0;
      mWe        = 0;
      cpuGntLast = 0;
      dmaGntLast = 0;
      mMemAddr   = '0;
      mMemWdata  = '0;
      mCap       = '0;
      mCpuRdata  = '0;
      mDmaRdata  = '0;
   endtask

   // Per-cycle compare against the model, then advance the model one cycle
   always @(negedge clk) begin : compareProc
      bit acc, resp, cr, dr, elig, take;
      int w;
      if (!rst_n) begin
         modelReset();
      end else begin
         acc  = mActive && (cyc > mStart) && (cyc <= mStart + ML);
         resp = mActive && (cyc == mStart + ML + 1);
         if (resp && !mWe) begin
            if (mOwner == CPU) mCpuRdata = mCap;
            else               mDmaRdata = mCap;
         end
         checkOutput("mem_rd",     mem_rd,     acc && !mWe);
         checkOutput("mem_wr",     mem_wr,     acc && mWe);
         checkOutput("cpu_gnt",    cpu_gnt,    resp && mOwner == CPU);
         checkOutput("cpu_rvalid", cpu_rvalid, resp && mOwner == CPU && !mWe);
         checkOutput("dma_gnt",    dma_gnt,    resp && mOwner == DMA);
         checkOutput("dma_rvalid", dma_rvalid, resp && mOwner == DMA && !mWe);
         checkOutput("cpu_stall",  cpu_stall,  cpu_req && !(resp && mOwner == CPU));
         checkOutput("mem_addr",   mem_addr,   mMemAddr);
         checkOutput("mem_wdata",  mem_wdata,  mMemWdata);
         checkOutput("cpu_rdata",  cpu_rdata,  mCpuRdata);
         checkOutput("dma_rdata",  dma_rdata,  mDmaRdata);
         cpuGntLast = resp && mOwner == CPU;
         dmaGntLast = resp && mOwner == DMA;
         if (acc && cyc == mStart + ML) mCap = mem_rdata;
         if (!mActive || resp) begin
            cr   = cpu_req && !(resp && mOwner == CPU);
            dr   = dma_req && !(resp && mOwner == DMA);
            elig = resp && mOwner == DMA && dma_lock && dma_req;
            take = elig && (mLockCnt < LM - 1);
            w    = -1;
            if (take) w = DMA;
`ifdef MEM_ARB_RR_EN
            else if (cr && dr) w = (mLastOwner == CPU) ? DMA : CPU;
`else
            else if (cr && dr) w = CPU;
`endif
            else if (cr) w = CPU;
            else if (dr) w = DMA;
            if (take) mLockCnt++;
            else if (w == CPU || elig) mLockCnt = 0;
            if (w >= 0) begin
               mActive    = 1;
               mStart     = cyc;
               mOwner     = w;
               mLastOwner = w;
               mWe        = (w == CPU) ? cpu_we    : dma_we;
               mMemAddr   = (w == CPU) ? cpu_addr  : dma_addr;
               mMemWdata  = (w == CPU) ? cpu_wdata : dma_wdata;
            end else if (resp) begin
               mActive = 0;
            end
         end
         cyc++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst_n    = 1'b0;
      cpu_req  = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req  = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_lock = 0;
      mem_rdata = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // One cycle of protocol-respecting random traffic on both requesters
   task automatic applyStimulus();
      if (cpu_req && !cpuGntLast) begin
         if ($urandom_range(0, 31) == 0) cpu_req = 0;
      end else if ($urandom_range(0, 1) == 1) begin
         cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      end else begin
         cpu_req = 0;
      end
      if (dma_req && !dmaGntLast) begin
         if ($urandom_range(0, 31) == 0) dma_req = 0;
      end else if ($urandom_range(0, 2) != 0) begin
         dma_req = 1; dma_we = 1'($urandom); dma_addr = AW'($urandom); dma_wdata = DW'($urandom);
      end else begin
         dma_req = 0;
      end
      dma_lock  = ($urandom_range(0, 3) != 0);
      mem_rdata = DW'($urandom);
   endtask

   initial begin : mainProc
      logic [7:0]    rdBits, stBits, gBits, rvBits;
      logic [DW-1:0] rdataAtGnt;
      logic [AW-1:0] addrAtStrobe;
      logic [DW-1:0] wdataAtStrobe;
      int            cpuG, dmaG, dmaCount, wrCnt, rdCnt, gCnt, rvCnt;
      bit            g, sawG, sawS;

      rst_n = 1'b0;
      resetDut();
      rst_n = 1'b0;
      #1;
      checkOutput("reset_mem_rd",    mem_rd,    0);
      checkOutput("reset_mem_wr",    mem_wr,    0);
      checkOutput("reset_cpu_gnt",   cpu_gnt,   0);
      checkOutput("reset_dma_gnt",   dma_gnt,   0);
      checkOutput("reset_mem_addr",  mem_addr,  0);
      checkOutput("reset_cpu_rdata", cpu_rdata, 0);

      // single CPU read, memory returns 0xA5
      resetDut();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; mem_rdata = 8'hA5;
      rdBits = 0; stBits = 0; gBits = 0; rvBits = 0; rdataAtGnt = 0; addrAtStrobe = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         rdBits[k] = mem_rd; stBits[k] = cpu_stall; gBits[k] = cpu_gnt; rvBits[k] = cpu_rvalid;
         if (cpu_gnt) rdataAtGnt = cpu_rdata;
         if (mem_rd) addrAtStrobe = mem_addr;
         g = cpu_gnt;
         tick();
         if (g) cpu_req = 0;
      end
      checkOutput("t1_rd_cycles",    rdBits,       8'b0000_1110);
      checkOutput("t1_stall_cycles", stBits,       8'b0000_1111);
      checkOutput("t1_gnt_cycles",   gBits,        8'b0001_0000);
      checkOutput("t1_rvalid",       rvBits,       8'b0001_0000);
      checkOutput("t1_rdata",        rdataAtGnt,   8'hA5);
      checkOutput("t1_addr",         addrAtStrobe, 16'h0010);

      // simultaneous CPU and DMA reads: CPU first, DMA one access later
      resetDut();
      cpu_req = 1; cpu_addr = 16'h0020; dma_req = 1; dma_addr = 16'h0030;
      cpuG = -1; dmaG = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (cpu_gnt && cpuG < 0) cpuG = k;
         if (dma_gnt && dmaG < 0) dmaG = k;
         sawG = cpu_gnt; g = dma_gnt;
         tick();
         if (sawG) cpu_req = 0;
         if (g) dma_req = 0;
      end
      checkOutput("t2_cpu_gnt_cycle", cpuG, 4);
      checkOutput("t2_dma_gnt_cycle", dmaG, 8);

      // locked DMA stream against a waiting CPU: 4 DMA grants, then CPU
      resetDut();
      dma_req = 1; dma_lock = 1; dma_addr = 16'h0400;
      cpuG = -1; dmaCount = 0;
      for (int k = 0; k < 60 && cpuG < 0; k++) begin
         @(negedge clk);
         if (dma_gnt) dmaCount++;
         if (cpu_gnt) cpuG = k;
         tick();
         if (k == 0) begin cpu_req = 1; cpu_addr = 16'h0500; end
      end
      cpu_req = 0; dma_req = 0; dma_lock = 0;
      checkOutput("t3_dma_grants",    dmaCount, 4);
      checkOutput("t3_cpu_gnt_cycle", cpuG,     20);

      // DMA write 0x3C to 0x0100
      resetDut();
      dma_req = 1; dma_we = 1; dma_addr = 16'h0100; dma_wdata = 8'h3C;
      wrCnt = 0; rdCnt = 0; gCnt = 0; rvCnt = 0; addrAtStrobe = 0; wdataAtStrobe = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (mem_wr) begin wrCnt++; addrAtStrobe = mem_addr; wdataAtStrobe = mem_wdata; end
         if (mem_rd) rdCnt++;
         if (dma_gnt) gCnt++;
         if (dma_rvalid) rvCnt++;
         g = dma_gnt;
         tick();
         if (g) dma_req = 0;
      end
      checkOutput("t4_wr_cycles", wrCnt,         3);
      checkOutput("t4_rd_cycles", rdCnt,         0);
      checkOutput("t4_gnt_count", gCnt,          1);
      checkOutput("t4_rvalid",    rvCnt,         0);
      checkOutput("t4_addr",      addrAtStrobe,  16'h0100);
      checkOutput("t4_wdata",     wdataAtStrobe, 8'h3C);

      // reset asserted in the middle of a CPU write
      resetDut();
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'h77;
      tick();
      checkOutput("t5_wr_before_reset", mem_wr, 1);
      rst_n = 1'b0; cpu_req = 0;
      #1;
      checkOutput("t5_wr_in_reset",  mem_wr,  0);
      checkOutput("t5_rd_in_reset",  mem_rd,  0);
      checkOutput("t5_gnt_in_reset", cpu_gnt, 0);
      tick();
      rst_n = 1'b1;
      sawG = 0; sawS = 0;
      repeat (ML + 3) begin
         @(negedge clk);
         if (cpu_gnt) sawG = 1;
         if (mem_rd || mem_wr) sawS = 1;
         tick();
      end
      checkOutput("t5_no_gnt_after",    sawG, 0);
      checkOutput("t5_no_strobe_after", sawS, 0);

      // randomized traffic, checked cycle by cycle by the model
      resetDut();
      repeat (3000) begin
         applyStimulus();
         tick();
      end
      cpu_req = 0; dma_req = 0; dma_lock = 0;
      repeat (2 * ML + 4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
